// File: rtl/tetris_input_ctrl_if.sv
// Command handshake between the input controller and the game logic.
interface tetris_input_ctrl_if;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd, input cmd_ready);
  modport slave  (input cmd_valid, input cmd, output cmd_ready);
endinterface

// File: rtl/tetris_input_ctrl.sv
// Button pulses -> game commands: auto-repeat for left/right/down,
// priority arbitration into a small command FIFO.
module tetris_input_ctrl #(
  parameter int DAS_CYCLES = 4250000,
  parameter int ARR_CYCLES = 1250000,
  parameter int DEPTH      = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic left_en,
  input  logic left_dis,
  input  logic right_en,
  input  logic right_dis,
  input  logic down_en,
  input  logic down_dis,
  input  logic rot_en,
  input  logic drop_en,
  tetris_input_ctrl_if.master cmd_if,
  output logic evt_dropped
);
  localparam int MAXC = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
  localparam int CW   = $clog2(MAXC);
  localparam int AW   = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;

  // pending/event bit index = command code - 1: 0 LEFT, 1 RIGHT, 2 DOWN, 3 ROTATE, 4 DROP
  logic [4:0]    pend;
  logic [2:0]    held;
  rpt_state_t    state;
  logic [1:0]    act;
  logic [CW-1:0] cnt;

  logic [2:0]    fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  logic [2:0]    press, rel, act_oh;
  logic          term, tick;
  logic [4:0]    ev, gnt;
  logic [2:0]    gcode;
  logic          push, pop;

  always_comb begin
    press  = {down_en, right_en, left_en};
    rel    = {down_dis, right_dis, left_dis};
    act_oh = 3'b001 << act;
    term   = (state == DELAY)  ? (cnt == CW'(DAS_CYCLES - 1)) :
             (state == REPEAT) ? (cnt == CW'(ARR_CYCLES - 1)) : 1'b0;
    tick   = term && held[act];
    // a press coinciding with a repeat tick of the same key merges into one event
    ev     = {drop_en, rot_en, press | (tick ? act_oh : 3'b000)};

    gnt   = '0;
    gcode = '0;
    if      (pend[4]) begin gnt[4] = 1'b1; gcode = 3'd5; end
    else if (pend[3]) begin gnt[3] = 1'b1; gcode = 3'd4; end
    else if (pend[0]) begin gnt[0] = 1'b1; gcode = 3'd1; end
    else if (pend[1]) begin gnt[1] = 1'b1; gcode = 3'd2; end
    else if (pend[2]) begin gnt[2] = 1'b1; gcode = 3'd3; end

    // no bypass: a full FIFO refuses the write even when popping this cycle
    push = (|pend) && (count < (AW+1)'(DEPTH));
    pop  = (count != '0) && cmd_if.cmd_ready;
  end

  assign cmd_if.cmd_valid = (count != '0);
  assign cmd_if.cmd       = (count != '0) ? fifo_mem[rd_ptr] : 3'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend        <= '0;
      held        <= '0;
      state       <= IDLE;
      act         <= '0;
      cnt         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      evt_dropped <= 1'b0;
    end else begin
      evt_dropped <= |(ev & pend);
      pend        <= (pend & ~(push ? gnt : 5'b0)) | (ev & ~pend);

      if (push) begin
        fifo_mem[wr_ptr] <= gcode;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;

      held <= (held & ~rel) | press;

      case (state)
        DELAY: begin
          if (term) begin cnt <= '0; state <= REPEAT; end
          else      cnt <= cnt + 1'b1;
        end
        REPEAT: begin
          if (term) cnt <= '0;
          else      cnt <= cnt + 1'b1;
        end
        default: cnt <= '0;
      endcase

      // releasing the active key stops repeat even if another key is still down
      if (state != IDLE && |(rel & act_oh)) begin
        state <= IDLE;
        cnt   <= '0;
      end
      if (|press) begin
        state <= DELAY;
        cnt   <= '0;
        if      (press[0]) act <= 2'd0;
        else if (press[1]) act <= 2'd1;
        else               act <= 2'd2;
      end
    end
  end
endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Directed bench for tetris_input_ctrl with DAS=10, ARR=4, DEPTH=4.
module tb_tetris_input_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic left_en, left_dis, right_en, right_dis, down_en, down_dis, rot_en, drop_en;
  logic evt_dropped;

  tetris_input_ctrl_if bus();

  tetris_input_ctrl #(.DAS_CYCLES(10), .ARR_CYCLES(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .left_en(left_en), .left_dis(left_dis),
    .right_en(right_en), .right_dis(right_dis),
    .down_en(down_en), .down_dis(down_dis),
    .rot_en(rot_en), .drop_en(drop_en),
    .cmd_if(bus.master),
    .evt_dropped(evt_dropped)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] M_LEN  = 8'h01, M_LDIS = 8'h02, M_REN  = 8'h04, M_RDIS = 8'h08;
  localparam logic [7:0] M_DEN  = 8'h10, M_DDIS = 8'h20, M_ROT  = 8'h40, M_DROP = 8'h80;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int drop_cnt = 0;
  int log_cyc[$];
  logic [2:0] log_cmd[$];

  always @(posedge clk) cyc <= cyc + 1;

  // accepted commands tagged with the edge after which they were on the bus
  always @(negedge clk) begin
    if (bus.cmd_valid && bus.cmd_ready) begin
      log_cyc.push_back(cyc);
      log_cmd.push_back(bus.cmd);
    end
    if (evt_dropped) drop_cnt++;
  end

  // caller sits at a negedge; mask is sampled at edge t, returns at negedge after t
  task automatic drive(input logic [7:0] m, output int t);
    t = cyc + 1;
    {drop_en, rot_en, down_dis, down_en, right_dis, right_en, left_dis, left_en} = m;
    @(negedge clk);
    {drop_en, rot_en, down_dis, down_en, right_dis, right_en, left_dis, left_en} = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle(3);
    n_tests++; if (bus.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", bus.cmd_valid); end
    n_tests++; if (bus.cmd !== 3'd0) begin n_fail++; $display("FAIL reset_cmd got %0d want 0", bus.cmd); end
    n_tests++; if (evt_dropped !== 1'b0) begin n_fail++; $display("FAIL reset_dropped got %0b want 0", evt_dropped); end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_single_tap;
    int t0, tx, b;
    b = log_cmd.size();
    drive(M_LEN, t0);
    n_tests++; if (bus.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL tap_latency valid got %0b want 0", bus.cmd_valid); end
    idle(1);
    n_tests++; if (bus.cmd_valid !== 1'b1 || bus.cmd !== 3'd1) begin n_fail++; $display("FAIL tap_head got v=%0b c=%0d want v=1 c=1", bus.cmd_valid, bus.cmd); end
    wait_until(t0 + 4);
    drive(M_LDIS, tx);
    idle(20);
    n_tests++; if (log_cmd.size() - b !== 1) begin n_fail++; $display("FAIL tap_count got %0d want 1", log_cmd.size() - b); end
    if (log_cmd.size() > b) begin
      n_tests++; if (log_cyc[b] !== t0 + 1 || log_cmd[b] !== 3'd1) begin n_fail++; $display("FAIL tap_entry got edge+%0d cmd %0d want edge+1 cmd 1", log_cyc[b] - t0, log_cmd[b]); end
    end
  endtask

  task automatic test_autorepeat;
    int t0, tx, b;
    int ex[7] = '{1, 11, 15, 19, 23, 27, 31};
    b = log_cmd.size();
    drive(M_LEN, t0);
    wait_until(t0 + 29);
    drive(M_LDIS, tx);
    idle(20);
    n_tests++; if (log_cmd.size() - b !== 7) begin n_fail++; $display("FAIL repeat_count got %0d want 7", log_cmd.size() - b); end
    for (int i = 0; i < 7; i++) begin
      if (b + i < log_cmd.size()) begin
        n_tests++; if (log_cyc[b+i] !== t0 + ex[i] || log_cmd[b+i] !== 3'd1) begin n_fail++; $display("FAIL repeat_%0d got edge+%0d cmd %0d want edge+%0d cmd 1", i, log_cyc[b+i] - t0, log_cmd[b+i], ex[i]); end
      end
    end
  endtask

  task automatic test_simultaneous;
    int t0, tx, b, d0;
    logic [2:0] ek[3] = '{3'd5, 3'd4, 3'd2};
    b = log_cmd.size();
    d0 = drop_cnt;
    drive(M_DROP | M_ROT | M_REN, t0);
    wait_until(t0 + 3);
    drive(M_RDIS, tx);
    idle(15);
    n_tests++; if (log_cmd.size() - b !== 3) begin n_fail++; $display("FAIL simul_count got %0d want 3", log_cmd.size() - b); end
    for (int i = 0; i < 3; i++) begin
      if (b + i < log_cmd.size()) begin
        n_tests++; if (log_cyc[b+i] !== t0 + 1 + i || log_cmd[b+i] !== ek[i]) begin n_fail++; $display("FAIL simul_%0d got edge+%0d cmd %0d want edge+%0d cmd %0d", i, log_cyc[b+i] - t0, log_cmd[b+i], i + 1, ek[i]); end
      end
    end
    n_tests++; if (drop_cnt !== d0) begin n_fail++; $display("FAIL simul_dropped got %0d want 0", drop_cnt - d0); end
  endtask

  task automatic test_backpressure;
    int t, td, b, d0;
    logic [2:0] ek[5] = '{3'd5, 3'd4, 3'd1, 3'd2, 3'd3};
    bus.cmd_ready = 1'b0;
    b = log_cmd.size();
    d0 = drop_cnt;
    drive(M_DROP, t); drive(M_ROT, t); drive(M_LEN, t); drive(M_REN, t); drive(M_DEN, t);
    drive(M_DDIS, t); drive(M_LDIS, t); drive(M_RDIS, t);
    idle(5);
    n_tests++; if (bus.cmd_valid !== 1'b1 || bus.cmd !== 3'd5) begin n_fail++; $display("FAIL bp_head got v=%0b c=%0d want v=1 c=5", bus.cmd_valid, bus.cmd); end
    n_tests++; if (drop_cnt !== d0) begin n_fail++; $display("FAIL bp_no_drop got %0d want 0", drop_cnt - d0); end
    drive(M_DEN, td);
    n_tests++; if (evt_dropped !== 1'b1) begin n_fail++; $display("FAIL bp_drop_pulse got %0b want 1", evt_dropped); end
    idle(1);
    n_tests++; if (evt_dropped !== 1'b0) begin n_fail++; $display("FAIL bp_drop_end got %0b want 0", evt_dropped); end
    drive(M_DDIS, t);
    idle(3);
    n_tests++; if (drop_cnt - d0 !== 1) begin n_fail++; $display("FAIL bp_drop_count got %0d want 1", drop_cnt - d0); end
    bus.cmd_ready = 1'b1;
    idle(10);
    n_tests++; if (log_cmd.size() - b !== 5) begin n_fail++; $display("FAIL bp_count got %0d want 5", log_cmd.size() - b); end
    for (int i = 0; i < 5; i++) begin
      if (b + i < log_cmd.size()) begin
        n_tests++; if (log_cmd[b+i] !== ek[i]) begin n_fail++; $display("FAIL bp_order_%0d got %0d want %0d", i, log_cmd[b+i], ek[i]); end
      end
    end
    n_tests++; if (bus.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained got %0b want 0", bus.cmd_valid); end
  endtask

  task automatic test_key_switch;
    int t0, t1, tx, b;
    int ec[5];
    logic [2:0] ek[5] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2};
    b = log_cmd.size();
    drive(M_LEN, t0);
    wait_until(t0 + 15);
    drive(M_REN, t1);
    wait_until(t1 + 11);
    drive(M_RDIS, tx);
    idle(30);
    drive(M_LDIS, tx);
    idle(5);
    ec = '{t0 + 1, t0 + 11, t0 + 15, t1 + 1, t1 + 11};
    n_tests++; if (log_cmd.size() - b !== 5) begin n_fail++; $display("FAIL switch_count got %0d want 5", log_cmd.size() - b); end
    for (int i = 0; i < 5; i++) begin
      if (b + i < log_cmd.size()) begin
        n_tests++; if (log_cyc[b+i] !== ec[i] || log_cmd[b+i] !== ek[i]) begin n_fail++; $display("FAIL switch_%0d got cyc %0d cmd %0d want cyc %0d cmd %0d", i, log_cyc[b+i], log_cmd[b+i], ec[i], ek[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_repeat;
    int t0, tx, b;
    bus.cmd_ready = 1'b0;
    drive(M_LEN, t0);
    wait_until(t0 + 11);
    n_tests++; if (bus.cmd_valid !== 1'b1 || bus.cmd !== 3'd1) begin n_fail++; $display("FAIL rstrep_queued got v=%0b c=%0d want v=1 c=1", bus.cmd_valid, bus.cmd); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++; if (bus.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL rstrep_valid got %0b want 0", bus.cmd_valid); end
    n_tests++; if (bus.cmd !== 3'd0) begin n_fail++; $display("FAIL rstrep_cmd got %0d want 0", bus.cmd); end
    n_tests++; if (evt_dropped !== 1'b0) begin n_fail++; $display("FAIL rstrep_dropped got %0b want 0", evt_dropped); end
    bus.cmd_ready = 1'b1;
    b = log_cmd.size();
    idle(30);
    n_tests++; if (log_cmd.size() - b !== 0) begin n_fail++; $display("FAIL rstrep_no_repeat got %0d want 0", log_cmd.size() - b); end
    n_tests++; if (bus.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL rstrep_idle got %0b want 0", bus.cmd_valid); end
    drive(M_LDIS, tx);
    idle(3);
  endtask

  initial begin
    rst = 1'b1;
    {drop_en, rot_en, down_dis, down_en, right_dis, right_en, left_dis, left_en} = '0;
    bus.cmd_ready = 1'b1;
    @(negedge clk);
    test_reset;
    test_single_tap;
    test_autorepeat;
    test_simultaneous;
    test_backpressure;
    test_key_switch;
    test_reset_mid_repeat;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
